// File: rtl/spi_ram_master.sv
// SPI mode-0 master for the SPI RAM slave: shifts out {cmd, payload} MSB first
// and, for read-data commands, clocks 8 bits back from MISO after a turnaround.
module spi_ram_master #(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned TURN_BITS = 1,
  parameter int unsigned GUARD     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] payload,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 4;
  // FINISH and the IDLE accept cycle already give two high cycles of SS_n
  localparam int unsigned GCNT_W = (GUARD > 3) ? $clog2(GUARD - 2) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_OUT, S_TURN, S_SHIFT_IN, S_FINISH, S_GUARD
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [8:0]          sh_q, sh_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [6:0]          rd_sh_q, rd_sh_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                ss_n_q, ss_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_valid_q, rd_valid_d;
  logic                phase_end;
  logic                sclk_fall;

  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign sclk_fall = phase_end && sclk_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    gcnt_d     = gcnt_q;
    sh_d       = sh_q;
    cmd_d      = cmd_q;
    rd_sh_d    = rd_sh_q;
    rd_data_d  = rd_data_q;
    ss_n_d     = ss_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;

    if (state_q == S_SHIFT_OUT || state_q == S_TURN || state_q == S_SHIFT_IN) begin
      if (phase_end) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = S_SHIFT_OUT;
          sh_d    = {cmd[0], payload};
          cmd_d   = cmd;
          rd_sh_d = '0;
          mosi_d  = cmd[1];
          ss_n_d  = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SHIFT_OUT: begin
        if (sclk_fall) begin
          if (bit_q == BIT_W'(9)) begin
            bit_d = '0;
            if (cmd_q == 2'b11) begin
              mosi_d  = 1'b0;
              state_d = (TURN_BITS == 0) ? S_SHIFT_IN : S_TURN;
            end else begin
              state_d = S_FINISH;
              ss_n_d  = 1'b1;
              sclk_d  = 1'b0;
              mosi_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            mosi_d = sh_q[8];
            sh_d   = {sh_q[7:0], 1'b0};
          end
        end
      end
      S_TURN: begin
        if (sclk_fall) begin
          if (bit_q == BIT_W'(TURN_BITS - 1)) begin
            bit_d   = '0;
            state_d = S_SHIFT_IN;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_SHIFT_IN: begin
        if (sclk_fall) begin
          rd_sh_d = {rd_sh_q[5:0], MISO};
          if (bit_q == BIT_W'(7)) begin
            state_d    = S_FINISH;
            rd_data_d  = {rd_sh_q, MISO};
            rd_valid_d = 1'b1;
            ss_n_d     = 1'b1;
            sclk_d     = 1'b0;
            mosi_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_FINISH: begin
        gcnt_d = '0;
        if (GUARD > 2) begin
          state_d = S_GUARD;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_GUARD: begin
        if (gcnt_q == GCNT_W'(GUARD - 3)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      gcnt_q     <= '0;
      sh_q       <= '0;
      cmd_q      <= '0;
      rd_sh_q    <= '0;
      rd_data_q  <= '0;
      ss_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      gcnt_q     <= gcnt_d;
      sh_q       <= sh_d;
      cmd_q      <= cmd_d;
      rd_sh_q    <= rd_sh_d;
      rd_data_q  <= rd_data_d;
      ss_n_q     <= ss_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign SS_n     = ss_n_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: table of frames on a CLK_DIV=1 instance,
// plus CLK_DIV=3 timing, ignored start, back-to-back and mid-frame reset cases.
module tb_spi_ram_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start1, start3, miso1, miso3, sel;
  logic [1:0] cmd;
  logic [7:0] payload;
  logic       busy1, done1, rv1, ss1, sclk1, mosi1;
  logic       busy3, done3, rv3, ss3, sclk3, mosi3;
  logic [7:0] rd1, rd3;

  spi_ram_master #(.CLK_DIV(1), .TURN_BITS(1), .GUARD(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .cmd(cmd), .payload(payload),
    .busy(busy1), .done(done1), .rd_data(rd1), .rd_valid(rv1),
    .SS_n(ss1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1));

  spi_ram_master #(.CLK_DIV(3), .TURN_BITS(1), .GUARD(2)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .cmd(cmd), .payload(payload),
    .busy(busy3), .done(done3), .rd_data(rd3), .rd_valid(rv3),
    .SS_n(ss3), .SCLK(sclk3), .MOSI(mosi3), .MISO(miso3));

  assign miso3 = 1'b0;

  // Observed instance selected by sel
  logic       m_ss, m_sclk, m_mosi, m_busy, m_done, m_rv;
  logic [7:0] m_rd;
  assign m_ss   = sel ? ss3   : ss1;
  assign m_sclk = sel ? sclk3 : sclk1;
  assign m_mosi = sel ? mosi3 : mosi1;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_rv   = sel ? rv3   : rv1;
  assign m_rd   = sel ? rd3   : rd1;

  // Slave MISO model: 10 cmd rises, 1 turnaround rise, then 8 data bits
  logic [7:0] miso_byte;
  int         rise_cnt;
  always @(posedge sclk1 or posedge ss1) begin
    if (ss1) begin
      rise_cnt = 0;
      miso1    = 1'b0;
    end else begin
      if (rise_cnt >= 11 && rise_cnt < 19) miso1 = miso_byte[18 - rise_cnt];
      rise_cnt = rise_cnt + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Frame observation results
  logic [9:0] o_bits;
  logic [7:0] o_rd;
  int o_low, o_done, o_rv, o_minrun, o_maxrun, o_unstable, o_fin;

  task automatic kick(input logic [1:0] c, input logic [7:0] p);
    cmd = c; payload = p;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic observe();
    logic prev_ss, prev_sclk, prev_mosi, lvl, seen;
    int run, rises;
    o_bits = '0; o_rd = '0; o_low = 0; o_done = 0; o_rv = 0;
    o_minrun = 1000; o_maxrun = 0; o_unstable = 0; o_fin = 0;
    prev_ss = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; lvl = 1'b0; seen = 1'b0;
    run = 0; rises = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!m_ss) begin
        seen = 1'b1;
        o_low++;
        if (prev_ss) begin
          lvl = m_sclk; run = 1;
        end else if (m_sclk == lvl) begin
          run++;
        end else begin
          if (run < o_minrun) o_minrun = run;
          if (run > o_maxrun) o_maxrun = run;
          lvl = m_sclk; run = 1;
        end
        if (m_sclk && !prev_sclk) begin
          if (rises < 10) o_bits = {o_bits[8:0], m_mosi};
          rises++;
        end
        if (m_sclk && prev_sclk && (m_mosi != prev_mosi)) o_unstable++;
      end else if (!prev_ss) begin
        if (run < o_minrun) o_minrun = run;
        if (run > o_maxrun) o_maxrun = run;
      end
      if (m_done) begin o_done++; o_rd = m_rd; end
      if (m_rv) o_rv++;
      prev_ss = m_ss; prev_sclk = m_sclk; prev_mosi = m_mosi;
      if (seen && !m_busy) begin o_fin = 1; break; end
      @(negedge clk);
    end
    chk("frame_completes", o_fin, 1);
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pay;
    logic [7:0] miso;
    logic [9:0] bits;
    int         low;
    int         rv;
    logic [7:0] rd;
  } vec_t;

  vec_t vt[5];

  initial begin
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0; cmd = '0; payload = '0;
    sel = 1'b0; miso_byte = '0;

    vt[0] = '{2'b00, 8'hA5, 8'h00, 10'b0010100101, 20, 0, 8'h00};
    vt[1] = '{2'b11, 8'h00, 8'h3C, 10'b1100000000, 38, 1, 8'h3C};
    vt[2] = '{2'b10, 8'h5A, 8'h00, 10'b1001011010, 20, 0, 8'h00};
    vt[3] = '{2'b01, 8'hC3, 8'h00, 10'b0111000011, 20, 0, 8'h00};
    vt[4] = '{2'b11, 8'h7F, 8'hA5, 10'b1101111111, 38, 1, 8'hA5};

    repeat (3) @(negedge clk);
    chk("rst_ss_n",   int'(ss1),   1);
    chk("rst_sclk",   int'(sclk1), 0);
    chk("rst_mosi",   int'(mosi1), 0);
    chk("rst_busy",   int'(busy1), 0);
    chk("rst_done",   int'(done1), 0);
    chk("rst_rvalid", int'(rv1),   0);
    chk("rst_rdata",  int'(rd1),   0);
    chk("rst_ss_n3",  int'(ss3),   1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single frames on the CLK_DIV=1 instance
    for (int i = 0; i < 5; i++) begin
      miso_byte = vt[i].miso;
      kick(vt[i].cmd, vt[i].pay);
      observe();
      chk($sformatf("v%0d_mosi_bits", i), int'(o_bits), int'(vt[i].bits));
      chk($sformatf("v%0d_ss_low", i),    o_low,        vt[i].low);
      chk($sformatf("v%0d_done_cnt", i),  o_done,       1);
      chk($sformatf("v%0d_rvalid_cnt", i), o_rv,        vt[i].rv);
      chk($sformatf("v%0d_sclk_min", i),  o_minrun,     1);
      chk($sformatf("v%0d_sclk_max", i),  o_maxrun,     1);
      if (vt[i].rv != 0) chk($sformatf("v%0d_rd_data", i), int'(o_rd), int'(vt[i].rd));
      @(negedge clk);
    end

    // CLK_DIV=3 write-data frame
    sel = 1'b1;
    kick(2'b01, 8'hFF);
    observe();
    chk("div3_mosi_bits", int'(o_bits), 10'b0111111111);
    chk("div3_ss_low",    o_low,    60);
    chk("div3_sclk_min",  o_minrun, 3);
    chk("div3_sclk_max",  o_maxrun, 3);
    chk("div3_mosi_stable", o_unstable, 0);
    chk("div3_done_cnt",  o_done,   1);
    chk("div3_rvalid_cnt", o_rv,    0);
    sel = 1'b0;
    @(negedge clk);

    // start during an active frame is ignored
    kick(2'b00, 8'hA5);
    fork
      observe();
      begin
        repeat (6) @(negedge clk);
        start1 = 1'b1; cmd = 2'b10; payload = 8'h55;
        @(negedge clk);
        start1 = 1'b0;
      end
    join
    chk("ign_mosi_bits", int'(o_bits), 10'b0010100101);
    chk("ign_ss_low",    o_low,  20);
    chk("ign_done_cnt",  o_done, 1);
    repeat (4) @(negedge clk);
    chk("ign_no_second_ss", int'(ss1),   1);
    chk("ign_no_second_busy", int'(busy1), 0);

    // start held high: back-to-back frames with a 2-cycle SS_n gap
    begin
      int t, gap;
      t = 0;
      start1 = 1'b1; cmd = 2'b00; payload = 8'h33;
      for (int g = 0; g < 2; g++) begin
        while (ss1 && t < 400) begin @(negedge clk); t++; end
        while (!ss1 && t < 400) begin @(negedge clk); t++; end
        gap = 0;
        while (ss1 && t < 400) begin gap++; @(negedge clk); t++; end
        chk($sformatf("hold_gap%0d", g), gap, 2);
      end
      start1 = 1'b0;
      t = 0;
      while (busy1 && t < 200) begin @(negedge clk); t++; end
      chk("hold_idle", int'(busy1), 0);
      @(negedge clk);
    end

    // Reset partway into a read-data frame
    miso_byte = 8'h96;
    kick(2'b11, 8'hFF);
    repeat (9) @(negedge clk);
    chk("pre_rst_ss_low", int'(ss1), 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ss_n",   int'(ss1),   1);
    chk("mid_rst_sclk",   int'(sclk1), 0);
    chk("mid_rst_mosi",   int'(mosi1), 0);
    chk("mid_rst_busy",   int'(busy1), 0);
    chk("mid_rst_done",   int'(done1), 0);
    chk("mid_rst_rvalid", int'(rv1),   0);
    chk("mid_rst_rdata",  int'(rd1),   0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_done", int'(done1), 0);
    chk("post_rst_rdata", int'(rd1), 0);

    miso_byte = 8'h3C;
    kick(2'b11, 8'h00);
    observe();
    chk("after_rst_ss_low", o_low, 38);
    chk("after_rst_done",   o_done, 1);
    chk("after_rst_rvalid", o_rv, 1);
    chk("after_rst_rdata",  int'(o_rd), 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
